// File: rtl/multicore_irq_ctrl_if.sv
// Avalon-MM slave bus for multicore_irq_ctrl: 3-bit word address, 16-bit data,
// registered readdata driven by the slave.
interface multicore_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/multicore_irq_ctrl.sv
// Two-core interrupt aggregator: pending latch, per-core enables, lowest-index ID.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on irq_in (adds 2 cycles of irq latency).
module multicore_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_in,
  multicore_irq_ctrl_if.slave bus,
  output logic                irq_core0,
  output logic                irq_core1
);

  localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

  logic [NUM_SRC-1:0] irq_s;
  logic [15:0] src, irq_prev, pending, edge_mode, en0, en1;
  logic [15:0] set, clr, id0, id1;
  logic [3:0]  wr;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      irq_s  <= '0;
    end else begin
      sync_q <= irq_in;
      irq_s  <= sync_q;
    end
  end
`else
  assign irq_s = irq_in;
`endif

  always_comb begin
    src = '0;
    src[NUM_SRC-1:0] = irq_s;
  end

  // Edge bits only fire on a 0->1 step; level bits fire whenever high.
  assign set = src & ~(edge_mode & irq_prev);
  assign wr  = (bus.chipselect && !bus.write_n) ? 4'(8'd1 << bus.address) : 4'd0;
  assign clr = wr[0] ? bus.writedata : 16'd0;

  function automatic logic [15:0] pick_id(input logic [15:0] v);
    pick_id = 16'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) pick_id = {1'b1, 11'd0, 4'(i)};
  endfunction

  assign id0 = pick_id(pending & en0);
  assign id1 = pick_id(pending & en1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev     <= '0;
      pending      <= '0;
      edge_mode    <= '0;
      en0          <= '0;
      en1          <= '0;
      irq_core0    <= 1'b0;
      irq_core1    <= 1'b0;
      bus.readdata <= '0;
    end else begin
      irq_prev  <= src;
      // Set is OR'd after the clear so a same-cycle set survives.
      pending   <= (pending & ~clr) | set;
      if (wr[1]) edge_mode <= bus.writedata & SRC_MASK;
      if (wr[2]) en0       <= bus.writedata & SRC_MASK;
      if (wr[3]) en1       <= bus.writedata & SRC_MASK;
      irq_core0 <= |(pending & en0);
      irq_core1 <= |(pending & en1);
      case (bus.address)
        3'd0:    bus.readdata <= pending;
        3'd1:    bus.readdata <= edge_mode;
        3'd2:    bus.readdata <= en0;
        3'd3:    bus.readdata <= en1;
        3'd4:    bus.readdata <= id0;
        3'd5:    bus.readdata <= id1;
        default: bus.readdata <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_irq_ctrl.sv
// Self-checking bench for multicore_irq_ctrl: directed scenarios plus a random
// run against a cycle-level behavioural model of the register set.
module tb_multicore_irq_ctrl;
  localparam int NUM_SRC = 8;
  localparam logic [15:0] MASK = 16'((32'd1 << NUM_SRC) - 32'd1);
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NUM_SRC-1:0] irq_in;
  logic irq_core0, irq_core1;
  multicore_irq_ctrl_if bus();

  multicore_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .bus(bus),
    .irq_core0(irq_core0), .irq_core1(irq_core1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit [15:0] m_pend, m_edge, m_en0, m_en1, m_prev, m_s1, m_s2, m_rd;
  bit        m_c0, m_c1;

  function automatic bit [15:0] m_id(input bit [15:0] v);
    for (int i = 0; i < 16; i++)
      if (v[i]) return 16'h8000 + 16'(i);
    return 16'h0000;
  endfunction

  task automatic m_clear();
    m_pend = 0; m_edge = 0; m_en0 = 0; m_en1 = 0; m_prev = 0;
    m_s1 = 0; m_s2 = 0; m_rd = 0; m_c0 = 0; m_c1 = 0;
  endtask

  // Advance one clock and move the model by the same edge.
  task automatic step();
    bit [15:0] src, eff, nxt;
    bit we, rise, cleared;
    @(posedge clk);
    src  = 16'(irq_in);
    eff  = (LAT == 0) ? src : m_s2;
    m_s2 = m_s1;
    m_s1 = src;
    we   = bus.chipselect && !bus.write_n;
    m_c0 = (m_pend & m_en0) != 0;
    m_c1 = (m_pend & m_en1) != 0;
    case (bus.address)
      3'd0: m_rd = m_pend;
      3'd1: m_rd = m_edge;
      3'd2: m_rd = m_en0;
      3'd3: m_rd = m_en1;
      3'd4: m_rd = m_id(m_pend & m_en0);
      3'd5: m_rd = m_id(m_pend & m_en1);
      default: m_rd = 0;
    endcase
    nxt = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rise    = m_edge[i] ? (eff[i] && !m_prev[i]) : eff[i];
      cleared = we && bus.address == 3'd0 && bus.writedata[i];
      nxt[i]  = rise || (m_pend[i] && !cleared);
    end
    if (we && bus.address == 3'd1) m_edge = bus.writedata & MASK;
    if (we && bus.address == 3'd2) m_en0  = bus.writedata & MASK;
    if (we && bus.address == 3'd3) m_en1  = bus.writedata & MASK;
    m_prev = eff;
    m_pend = nxt;
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'h0;
  endtask

  task automatic wr_reg(input int a, input logic [15:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 3'(a); bus.writedata = d;
    step();
    bus_idle();
  endtask

  task automatic rd_reg(input int a);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = 3'(a);
    step();
    bus.chipselect = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    bus.address = 3'd0;
    irq_in = '0;
    reset  = 1'b1;
    m_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (irq_core0 !== 1'b0 || irq_core1 !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b%b expected 00", irq_core0, irq_core1);
    end
    for (int a = 0; a < 6; a++) begin
      rd_reg(a);
      checks++;
      if (bus.readdata !== 16'h0000) begin
        errors++; $display("FAIL reset_read[%0d]: got %h expected 0000", a, bus.readdata);
      end
    end
  endtask

  task automatic test_level();
    int lat = 0;
    do_reset();
    wr_reg(2, 16'h0008);
    bus.address = 3'd0;
    irq_in = 8'h08;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step();
      if (irq_core0 === 1'b1) lat = k;
    end
    checks++;
    if (lat != 2 + LAT) begin
      errors++; $display("FAIL level_latency: got %0d expected %0d", lat, 2 + LAT);
    end
    checks++;
    if (bus.readdata !== 16'h0008) begin
      errors++; $display("FAIL level_pending: got %h expected 0008", bus.readdata);
    end
    checks++;
    if (irq_core1 !== 1'b0) begin
      errors++; $display("FAIL level_core1: got %b expected 0", irq_core1);
    end
    rd_reg(4);
    checks++;
    if (bus.readdata !== 16'h8003) begin
      errors++; $display("FAIL level_id0: got %h expected 8003", bus.readdata);
    end
    wr_reg(0, 16'h0008);
    rd_reg(0);
    checks++;
    if (bus.readdata !== 16'h0008) begin
      errors++; $display("FAIL level_clear_while_high: got %h expected 0008", bus.readdata);
    end
    irq_in = 8'h00;
    repeat (LAT + 1) step();
    wr_reg(0, 16'h0008);
    checks++;
    if (irq_core0 !== 1'b1) begin
      errors++; $display("FAIL level_core0_hold: got %b expected 1", irq_core0);
    end
    step();
    checks++;
    if (irq_core0 !== 1'b0) begin
      errors++; $display("FAIL level_core0_drop: got %b expected 0", irq_core0);
    end
    rd_reg(0);
    checks++;
    if (bus.readdata !== 16'h0000) begin
      errors++; $display("FAIL level_cleared: got %h expected 0000", bus.readdata);
    end
  endtask

  task automatic test_edge();
    do_reset();
    wr_reg(1, 16'h0002);
    wr_reg(3, 16'h0002);
    bus.address = 3'd0;
    irq_in = 8'h02;
    repeat (LAT + 2) step();
    checks++;
    if (irq_core1 !== 1'b1) begin
      errors++; $display("FAIL edge_core1_rise: got %b expected 1", irq_core1);
    end
    wr_reg(0, 16'h0002);
    step();
    checks++;
    if (irq_core1 !== 1'b0) begin
      errors++; $display("FAIL edge_core1_fall: got %b expected 0", irq_core1);
    end
    repeat (2) step();
    rd_reg(0);
    checks++;
    if (bus.readdata !== 16'h0000) begin
      errors++; $display("FAIL edge_no_reset: got %h expected 0000", bus.readdata);
    end
    irq_in = 8'h00;
    repeat (LAT + 2) step();
    checks++;
    if (irq_core1 !== 1'b0) begin
      errors++; $display("FAIL edge_core1_final: got %b expected 0", irq_core1);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wr_reg(1, 16'h0001);
    step();
    irq_in = 8'h01;
    wr_reg(0, 16'h0001);
    repeat (LAT) step();
    rd_reg(0);
    checks++;
    if (bus.readdata !== 16'h0001) begin
      errors++; $display("FAIL simul_set_wins: got %h expected 0001", bus.readdata);
    end
    irq_in = 8'h00;
  endtask

  task automatic test_priority();
    do_reset();
    wr_reg(1, 16'h0050);
    wr_reg(2, 16'hFFFF);
    wr_reg(3, 16'h0040);
    irq_in = 8'h50;
    step();
    irq_in = 8'h00;
    repeat (LAT + 1) step();
    rd_reg(4);
    checks++;
    if (bus.readdata !== 16'h8004) begin
      errors++; $display("FAIL prio_id0: got %h expected 8004", bus.readdata);
    end
    rd_reg(5);
    checks++;
    if (bus.readdata !== 16'h8006) begin
      errors++; $display("FAIL prio_id1: got %h expected 8006", bus.readdata);
    end
    rd_reg(2);
    checks++;
    if (bus.readdata !== MASK) begin
      errors++; $display("FAIL prio_en0_mask: got %h expected %h", bus.readdata, MASK);
    end
    wr_reg(0, 16'h0010);
    rd_reg(4);
    checks++;
    if (bus.readdata !== 16'h8006) begin
      errors++; $display("FAIL prio_id0_after_clear: got %h expected 8006", bus.readdata);
    end
    wr_reg(6, 16'hFFFF);
    rd_reg(6);
    checks++;
    if (bus.readdata !== 16'h0000) begin
      errors++; $display("FAIL addr6_read: got %h expected 0000", bus.readdata);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      irq_in         = NUM_SRC'($urandom);
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 2) != 0);
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = 16'($urandom);
      step();
      checks++;
      if (bus.readdata !== m_rd) begin
        errors++; $display("FAIL rand_readdata @%0d: got %h expected %h", n, bus.readdata, m_rd);
      end
      checks++;
      if (irq_core0 !== m_c0 || irq_core1 !== m_c1) begin
        errors++; $display("FAIL rand_irq @%0d: got %b%b expected %b%b", n, irq_core0, irq_core1, m_c0, m_c1);
      end
    end
    bus_idle();
    irq_in = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_reg(2, 16'h0004);
    bus.address = 3'd0;
    irq_in = 8'h04;
    repeat (LAT + 3) step();
    checks++;
    if (irq_core0 !== 1'b1 || bus.readdata !== 16'h0004) begin
      errors++; $display("FAIL areset_pre: got %b/%h expected 1/0004", irq_core0, bus.readdata);
    end
    #2 reset = 1'b1;
    m_clear();
    #1;
    checks++;
    if (irq_core0 !== 1'b0 || bus.readdata !== 16'h0000) begin
      errors++; $display("FAIL areset_drop: got %b/%h expected 0/0000", irq_core0, bus.readdata);
    end
    irq_in = 8'h00;
    #1 reset = 1'b0;
    rd_reg(0);
    checks++;
    if (bus.readdata !== 16'h0000 || irq_core0 !== 1'b0) begin
      errors++; $display("FAIL areset_pending: got %h/%b expected 0000/0", bus.readdata, irq_core0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    irq_in = '0;
    bus.address = 3'd0;
    bus_idle();
    test_reset();
    test_level();
    test_edge();
    test_simultaneous();
    test_priority();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
